// File: rtl/bnt_gesture.sv
// Button gesture classifier: single / double / long press events.
// Consumes a one-cycle press-start pulse (bnt_star) and the raw active-low
// button level. It emits one event code per gesture through a valid/ready
// handshake.
// Optional feature: define BNT_GESTURE_DROP_CNT_EN to add an 8-bit saturating
// drop_cnt output. It counts press starts discarded while an event is pending
// or while a long press is still held.
module bnt_gesture #(
  parameter int C_CLK_FREQ  = 100_000,  // KHz
  parameter int C_GAP_TIME  = 800,      // ms, double-click window
  parameter int C_LONG_TIME = 1500      // ms, long-press threshold
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bnt_star,
  input  logic       bnt,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code
`ifdef BNT_GESTURE_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  // KHz * ms gives the cycle count directly.
  localparam logic [31:0] GAP_CYC   = 32'(C_CLK_FREQ * C_GAP_TIME);
  localparam logic [31:0] LONG_CYC  = 32'(C_CLK_FREQ * C_LONG_TIME);
  localparam logic [31:0] GAP_LAST  = GAP_CYC - 32'd1;
  localparam logic [31:0] LONG_LAST = LONG_CYC - 32'd1;

  localparam logic [1:0] CODE_SINGLE = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;
  localparam logic [1:0] CODE_LONG   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    EMIT   = 3'd4,
    REL    = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        bnt_m;
  logic        bnt_s;

  // Two-flop synchronizer for the asynchronous button level; idles released (1).
  always_ff @(posedge clk) begin
    if (!reset) begin
      bnt_m <= 1'b1;
      bnt_s <= 1'b1;
    end else begin
      bnt_m <= bnt;
      bnt_s <= bnt_m;
    end
  end

  // Gesture FSM. evt_valid is registered and is high exactly while in EMIT.
  // evt_code keeps its last value outside EMIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (bnt_star) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1: begin
          cnt <= cnt + 32'd1;
          // Release wins over a same-cycle long expiry, so it is handled as a short press.
          if (bnt_s) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state     <= EMIT;
            evt_valid <= 1'b1;
            evt_code  <= CODE_LONG;
          end
        end
        WAIT2: begin
          cnt <= cnt + 32'd1;
          // A second press wins over a same-cycle gap expiry.
          if (bnt_star) begin
            state <= PRESS2;
          end else if (cnt == GAP_LAST) begin
            state     <= EMIT;
            evt_valid <= 1'b1;
            evt_code  <= CODE_SINGLE;
          end
        end
        PRESS2: begin
          // No timeout here: a held second press still resolves as a double.
          if (bnt_s) begin
            state     <= EMIT;
            evt_valid <= 1'b1;
            evt_code  <= CODE_DOUBLE;
          end
        end
        EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            // A long press may still be held; wait for its release before re-arming.
            state     <= (evt_code == CODE_LONG) ? REL : IDLE;
          end
        end
        REL: begin
          if (bnt_s) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BNT_GESTURE_DROP_CNT_EN
  // Count press starts that arrive while an event is pending or a long press is held.
  always_ff @(posedge clk) begin
    if (!reset)
      drop_cnt <= '0;
    else if (bnt_star && (state == EMIT || state == REL) && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/bnt_gesture.md
BNT_GESTURE -- requirements
Module: bnt_gesture

Interface
REQ-001 SHALL have parameter C_CLK_FREQ, default 100_000, clock frequency in KHz.
REQ-002 SHALL have parameter C_GAP_TIME, default 800, double-click gap window in ms; it must exceed the upstream one-shot time.
REQ-003 SHALL have parameter C_LONG_TIME, default 1500, long-press threshold in ms.
REQ-004 SHALL have port clk, input, 1 bit: single clock; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port bnt_star, input, 1 bit: one-cycle press-start pulse from the button one-shot stage.
REQ-007 SHALL have port bnt, input, 1 bit: raw button level, asynchronous, active-low (0 = pressed).
REQ-008 SHALL have port evt_ready, input, 1 bit: consumer accepts the event.
REQ-009 SHALL have port evt_valid, output, 1 bit: event available.
REQ-010 SHALL have port evt_code, output, 2 bits: 01 = single, 10 = double, 11 = long; 00 is unused.

Function
REQ-011 SHALL synchronize bnt through two flops, reset value 1, giving bnt_s; release means bnt_s == 1.
REQ-012 SHALL derive the cycle thresholds GAP_CYC = C_CLK_FREQ*C_GAP_TIME and LONG_CYC = C_CLK_FREQ*C_LONG_TIME, using a 32-bit timer cnt.
REQ-013 SHALL implement the states IDLE, PRESS1, WAIT2, PRESS2, EMIT and REL.
REQ-014 IDLE: bnt_star -> PRESS1 with cnt = 0; otherwise stay.
REQ-015 PRESS1: cnt increments each cycle; bnt_s == 1 -> WAIT2 with cnt = 0; cnt == LONG_CYC-1 with bnt_s == 0 -> EMIT with code 11.
REQ-016 PRESS1 tie-break: release and long expiry in the same cycle SHALL take WAIT2, which is short-press handling.
REQ-017 WAIT2: cnt increments; bnt_star -> PRESS2; cnt == GAP_CYC-1 -> EMIT with code 01.
REQ-018 WAIT2 tie-break: bnt_star and gap expiry in the same cycle SHALL take PRESS2.
REQ-019 PRESS2: bnt_s == 1 -> EMIT with code 10; there SHALL be no timeout, so a held second press still yields a double.
REQ-020 EMIT: evt_valid = 1, and evt_code SHALL stay stable until evt_valid & evt_ready.
REQ-021 On handshake, EMIT SHALL go to REL when the code is 11, otherwise to IDLE, with evt_valid = 0 in the following cycle.
REQ-022 REL: bnt_s == 1 -> IDLE; bnt_star in REL is ignored.
REQ-023 bnt_star in EMIT or REL SHALL be discarded, which counts as a drop event.
REQ-024 evt_valid SHALL be registered and asserted exactly while in EMIT.
REQ-025 Latency: evt_valid SHALL rise LONG_CYC cycles after PRESS1 entry for a long press, and GAP_CYC cycles after WAIT2 entry for a single.
REQ-026 Latency for a double: evt_valid SHALL rise 1 cycle after the release is seen on bnt_s.
REQ-027 evt_code SHALL hold its last value outside EMIT.

Reset
REQ-028 reset == 0 at a clk edge SHALL force: state IDLE, cnt 0, evt_valid 0, evt_code 00, sync flops 1, drop_cnt 0.
REQ-029 Reset asserted mid-operation, including during EMIT, SHALL discard the pending event without a handshake.
REQ-030 The first bnt_star SHALL be accepted in the first cycle after reset release.

Configuration
REQ-031 Macro BNT_GESTURE_DROP_CNT_EN defined: the block SHALL add output drop_cnt, 8 bits, incremented per REQ-023 drop event and saturating at 255.
REQ-032 Macro BNT_GESTURE_DROP_CNT_EN undefined: drop_cnt port and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (C_CLK_FREQ=1, C_GAP_TIME=20, C_LONG_TIME=50; evt_ready=1 unless stated)
REQ-033 Single: bnt_star at t0, bnt low 5 cycles then high -> one event, code 01, evt_valid high for 1 cycle, 20 cycles after WAIT2 entry.
REQ-034 Double: second bnt_star 10 cycles into WAIT2, release 3 cycles later -> one event, code 10, 1 cycle after bnt_s rises; no 01 emitted.
REQ-035 Long: bnt held low 60 cycles after bnt_star -> code 11 at 50 cycles after PRESS1 entry; release causes no further event.
REQ-036 Backpressure: evt_ready low 10 cycles during EMIT, bnt_star pulsed twice -> evt_code stable throughout, a single handshake, and drop_cnt = 2 with the macro defined.
REQ-037 Tie-breaks: release on cycle 49 of PRESS1 -> WAIT2, no 11; bnt_star on WAIT2 cycle 19 -> code 10.
REQ-038 Reset mid-PRESS1 and mid-EMIT -> evt_valid 0 next cycle, state IDLE, and the next bnt_star is processed normally.
